mem_io_responder: RTL and testbench

//  Responder for the byte-wide CPU memory bus (mem_a/mem_dout/mem_wr in, mem_din out) driven by the memory controller.

---
 rtl/mem_io_responder.sv | 149 ++++++++++++++
 tb/tb_mem_io_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus memory-mapped IO for the CPU memory bus.
//   RAM at every address with mem_a[17:16] != 2'b11, read latency one cycle,
//   read-before-write. IO region mem_a[17:16] == 2'b11, register chosen by mem_a[2:0]:
//     0 : wr pushes the UART TX FIFO, rd pops the RX byte (0 when none)
//     4 : wr sets sim_halt/halt_code (first write wins), rd returns {6'b0, rx_valid, tx_empty}
// Optional feature: define MEM_IO_RESP_RX_EN to build the UART RX holding register.
module mem_io_responder #(
    parameter int    RAM_ADDR_WID = 17,
    parameter int    TX_DEPTH     = 16,
    parameter int    FULL_MARGIN  = 2,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        sim_halt,
    output logic [7:0]  halt_code,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0] ram [0:(1 << RAM_ADDR_WID) - 1];

    logic [RAM_ADDR_WID-1:0] ram_addr;
    logic                    io_sel;
    logic [2:0]              reg_sel;
    logic                    ram_we;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    halt_wr;
    logic                    rx_rd;
    logic                    tx_empty;
    logic                    tx_full;
    logic [7:0]              io_rdata;
    logic                    rx_valid;
    logic [7:0]              rx_data;

    logic [7:0]  tx_mem [0:TX_DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign ram_addr = mem_a[RAM_ADDR_WID-1:0];
    assign io_sel   = (mem_a[17:16] == 2'b11);
    assign reg_sel  = mem_a[2:0];
    // The IO region never aliases onto RAM, even where RAM_ADDR_WID would cover it.
    assign ram_we   = mem_wr & ~io_sel;
    assign push_req = mem_wr & io_sel & (reg_sel == 3'd0);
    assign halt_wr  = mem_wr & io_sel & (reg_sel == 3'd4);
    // Only a genuine read of the data register consumes the RX byte.
    assign rx_rd    = ~mem_wr & io_sel & (reg_sel == 3'd0);

    assign tx_empty = (count == '0);
    assign tx_full  = (count == CW'(TX_DEPTH));
    assign pop      = uart_tx_valid & uart_tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok  = push_req & (~tx_full | pop);

    assign uart_tx_valid  = ~tx_empty;
    assign uart_tx_data   = tx_mem[rd_ptr];
    // Driven from the registered count only, so no combinational path from the bus.
    assign io_buffer_full = ((CW'(TX_DEPTH) - count) <= CW'(FULL_MARGIN));

    // Bits never decoded, plus the RX inputs when the RX register is not built.
    logic unused_bits;
    assign unused_bits = ^{mem_a, uart_rx_data, uart_rx_valid, rx_rd};

`ifdef MEM_IO_RESP_RX_EN
    // RX holding register: a new byte always wins, a read clears only if no new byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (uart_rx_valid) begin
            rx_valid <= 1'b1;
            rx_data  <= uart_rx_data;
        end else if (rx_rd) begin
            rx_valid <= 1'b0;
        end
    end
`else
    assign rx_valid = 1'b0;
    assign rx_data  = 8'h00;
`endif

    // IO read mux; undecoded offsets read zero.
    always_comb begin
        io_rdata = 8'h00;
        case (reg_sel)
            3'd0:    io_rdata = rx_valid ? rx_data : 8'h00;
            3'd4:    io_rdata = {6'b0, rx_valid, tx_empty};
            default: io_rdata = 8'h00;
        endcase
    end

    // Registered read data (old byte on write cycles) and the RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_din <= 8'h00;
        end else begin
            mem_din <= io_sel ? io_rdata : ram[ram_addr];
            if (ram_we) ram[ram_addr] <= mem_dout;
        end
    end

    // TX FIFO: storage, wrapping pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tx_mem[wr_ptr] <= mem_dout;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) tx_overflow <= 1'b1;
        end
    end

    // Halt latch: the first halt write fixes the code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sim_halt  <= 1'b0;
            halt_code <= 8'h00;
        end else if (halt_wr && !sim_halt) begin
            sim_halt  <= 1'b1;
            halt_code <= mem_dout;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a table of single-cycle bus accesses with
// expected read data, then hand sequences for the TX FIFO, RX, halt and async reset.
module tb_mem_io_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        sim_halt;
    logic [7:0]  halt_code;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    mem_io_responder dut (
        .clk(clk), .rst_n(rst_n), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .sim_halt(sim_halt), .halt_code(halt_code), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the edge.
    task automatic bus(input logic we, input logic [31:0] a, input logic [7:0] d);
        mem_wr   = we;
        mem_a    = a;
        mem_dout = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] a);
        bus(1'b0, a, 8'h00);
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0100, 8'h11, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 32'h0000_0101, 8'h22, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 32'h0000_0102, 8'h33, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 32'h0000_0103, 8'h44, 1'b0, 8'h00};
        vt[4]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h11};
        vt[5]  = '{1'b0, 32'h0000_0101, 8'h00, 1'b1, 8'h22};
        vt[6]  = '{1'b0, 32'h0000_0102, 8'h00, 1'b1, 8'h33};
        vt[7]  = '{1'b0, 32'h0000_0103, 8'h00, 1'b1, 8'h44};
        vt[8]  = '{1'b1, 32'h0000_0200, 8'hA5, 1'b0, 8'h00};
        vt[9]  = '{1'b0, 32'h0000_0200, 8'h00, 1'b1, 8'hA5};
        vt[10] = '{1'b1, 32'h0000_0200, 8'h5C, 1'b1, 8'hA5};  // read-before-write
        vt[11] = '{1'b0, 32'h0000_0200, 8'h00, 1'b1, 8'h5C};
        vt[12] = '{1'b0, 32'h0003_0200, 8'h00, 1'b1, 8'h00};  // IO, not RAM
        vt[13] = '{1'b0, 32'h0002_0100, 8'h00, 1'b1, 8'h11};  // bit 17 ignored by RAM
        vt[14] = '{1'b0, 32'hFFFC_0101, 8'h00, 1'b1, 8'h22};  // high bits ignored
        vt[15] = '{1'b1, 32'h0001_0203, 8'h66, 1'b0, 8'h00};
        vt[16] = '{1'b1, 32'h0003_0203, 8'h77, 1'b1, 8'h00};  // undecoded IO write
        vt[17] = '{1'b0, 32'h0001_0203, 8'h00, 1'b1, 8'h66};  // RAM untouched by IO
        vt[18] = '{1'b0, 32'h0003_0201, 8'h00, 1'b1, 8'h00};
        vt[19] = '{1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h01};  // status: tx empty

        rst_n = 1'b0; mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_tx_valid", uart_tx_valid, 1'b0);
        chk("rst_halt", {sim_halt, halt_code}, 9'h000);
        chk("rst_ovf", tx_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            bus(vt[i].we, vt[i].a, vt[i].d);
            if (vt[i].chk) chk($sformatf("vec%0d", i), mem_din, vt[i].exp);
        end

        // RX path
        idle(32'h0);
        uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
        idle(32'h0);
        uart_rx_valid = 1'b0;
`ifdef MEM_IO_RESP_RX_EN
        idle(32'h0003_0004); chk("rx_status_full", mem_din, 8'h03);
        idle(32'h0003_0000); chk("rx_read", mem_din, 8'h5A);
        idle(32'h0003_0004); chk("rx_status_clr", mem_din, 8'h01);
        uart_rx_data = 8'h11; uart_rx_valid = 1'b1;
        idle(32'h0);
        uart_rx_data = 8'h22;
        idle(32'h0003_0000); chk("rx_same_edge_old", mem_din, 8'h11);
        uart_rx_valid = 1'b0;
        idle(32'h0003_0004); chk("rx_same_edge_valid", mem_din, 8'h03);
        idle(32'h0003_0000); chk("rx_same_edge_new", mem_din, 8'h22);
`else
        idle(32'h0003_0004); chk("rx_off_status", mem_din, 8'h01);
        idle(32'h0003_0000); chk("rx_off_read", mem_din, 8'h00);
`endif

        // Fill the FIFO with the sink stalled
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, 32'h0003_0000, 8'h40 + 8'(i));
            if (i == 0)  chk("tx_valid_first", {uart_tx_valid, uart_tx_data}, 9'h140);
            if (i == 12) chk("full_at_13", io_buffer_full, 1'b0);
            if (i == 13) chk("full_at_14", io_buffer_full, 1'b1);
        end
        chk("no_ovf_at_16", tx_overflow, 1'b0);
        idle(32'h0003_0004); chk("status_not_empty", mem_din, 8'h00);

        // Push and pop on the same edge while full
        uart_tx_ready = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'hF0);
        uart_tx_ready = 1'b0;
        chk("pushpop_no_ovf", tx_overflow, 1'b0);
        chk("pushpop_head", uart_tx_data, 8'h41);
        chk("pushpop_full", io_buffer_full, 1'b1);

        // Drain and check order: 0x41..0x4F then 0xF0
        mem_wr = 1'b0;
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), {uart_tx_valid, uart_tx_data},
                {1'b1, (i < 15) ? (8'h41 + 8'(i)) : 8'hF0});
            @(posedge clk);
            #1;
        end
        chk("drain_empty", uart_tx_valid, 1'b0);
        chk("drain_not_full", io_buffer_full, 1'b0);
        uart_tx_ready = 1'b0;

        // Overflow on the 17th push with no pop
        for (int i = 0; i < 17; i++) bus(1'b1, 32'h0003_0000, 8'(i));
        chk("ovf_17", tx_overflow, 1'b1);
        chk("ovf_head", uart_tx_data, 8'h00);

        // Halt: first write wins
        bus(1'b1, 32'h0003_0004, 8'h07);
        chk("halt_set", {sim_halt, halt_code}, 9'h107);
        bus(1'b1, 32'h0003_0004, 8'h09);
        chk("halt_sticky", {sim_halt, halt_code}, 9'h107);

        // Reset mid drain, between edges
        uart_tx_ready = 1'b1;
        idle(32'h0000_0100);
        idle(32'h0000_0100);
        chk("pre_rst_din", mem_din, 8'h11);
        rst_n = 1'b0;
        #1;
        chk("arst_din", mem_din, 8'h00);
        chk("arst_tx", {uart_tx_valid, io_buffer_full}, 2'b00);
        chk("arst_halt", {sim_halt, halt_code}, 9'h000);
        chk("arst_ovf", tx_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        uart_tx_ready = 1'b0;
        idle(32'h0000_0100);
        chk("post_rst_ram", mem_din, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
